qc_sparse_mac: RTL and testbench

Parametrised sparse × dense quasi-cyclic multiply-accumulate engine for the KEM datapath. It computes, over NB circulant blocks of size R, the GF(2) sum of each dense vector rotated by every sparse position of its block. P rotations are processed per cycle, and the rotation direction is selectable. Mode 0 gives the syndrome/encoder product s = Σ b_j·h_j. Mode 1 gives the transpose product Σ b_j·h_jᵀ, which the decoder uses for counter updates. It replaces the fixed two-block, fixed-width syndrome path and adds ready/valid handshakes, abort and out-of-range detection.

---
 rtl/qc_pkg.sv | 18 +
 rtl/qc_rot_unit.sv | 32 +++
 rtl/qc_sparse_mac.sv | 176 +++++++++++++++++
 tb/tb_qc_sparse_mac.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qc_pkg.sv
// Shared constants and types for the quasi-cyclic KEM datapath
// (syndrome, encoder, decoder and the sparse MAC engine).
package qc_pkg;

    localparam int unsigned QC_R     = 127;
    localparam int unsigned QC_W     = 5;
    localparam int unsigned QC_POS_W = 8;

    localparam logic MODE_MUL       = 1'b0;
    localparam logic MODE_TRANSPOSE = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHold
    } state_e;

endpackage

// File: rtl/qc_rot_unit.sv
// Combinational circulant rotation of one R-bit block by a sparse position.
// dir=0 rotates left (x^pos), dir=1 rotates right (x^-pos); out-of-range positions yield zero.
module qc_rot_unit #(
    parameter int unsigned R     = 127,
    parameter int unsigned POS_W = 8
) (
    input  logic [R-1:0]     x,
    input  logic [POS_W-1:0] shift,
    input  logic             dir,
    output logic [R-1:0]     y,
    output logic             out_of_range
);

    localparam logic [POS_W-1:0] RPos = POS_W'(R);

    logic [POS_W-1:0] lshift;
    logic [POS_W:0]   base;
    logic [2*R-1:0]   wide;

    always_comb begin
        out_of_range = (shift >= RPos);
        lshift       = shift;
        // A right rotation is the left rotation by R-shift; keep shift 0 at 0 so lshift < R.
        if (dir && (shift != '0)) begin
            lshift = RPos - shift;
        end
        wide = {x, x};
        base = (POS_W + 1)'(R) - {1'b0, lshift};
        y    = out_of_range ? '0 : wide[base +: R];
    end

endmodule

// File: rtl/qc_sparse_mac.sv
// Sparse x dense quasi-cyclic multiply-accumulate over NB circulant blocks,
// P rotations per cycle, with ready/valid handshakes, abort and range checking.
module qc_sparse_mac
    import qc_pkg::*;
#(
    parameter int unsigned R     = QC_R,
    parameter int unsigned W     = QC_W,
    parameter int unsigned POS_W = QC_POS_W,
    parameter int unsigned NB    = 2,
    parameter int unsigned P     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  mode,
    input  logic [NB*R-1:0]       b_flat,
    input  logic [NB*W*POS_W-1:0] pos_flat,
    input  logic                  abort,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [R-1:0]          s,
    output logic                  err
);

    localparam int unsigned BlkW = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned KW   = $clog2(W + P + 1);

    localparam logic [KW-1:0]   WK      = KW'(W);
    localparam logic [KW-1:0]   PK      = KW'(P);
    localparam logic [BlkW-1:0] LastBlk = BlkW'(NB - 1);

    state_e                  state_q, state_d;
    logic [NB*R-1:0]         b_q, b_d;
    logic [NB*W*POS_W-1:0]   pos_q, pos_d;
    logic                    mode_q, mode_d;
    logic [R-1:0]            acc_q, acc_d;
    logic [BlkW-1:0]         blk_q, blk_d;
    logic [KW-1:0]           k_q, k_d;
    logic                    err_acc_q, err_acc_d;
    logic [R-1:0]            s_q, s_d;
    logic                    err_q, err_d;

    logic [R-1:0]            rot_x;
    logic [P-1:0][POS_W-1:0] rot_shift;
    logic [P-1:0][R-1:0]     rot_y;
    logic [P-1:0]            rot_oor;
    logic [P-1:0]            term_en;
    logic [R-1:0]            run_sum;
    logic                    run_oor;

    assign rot_x = b_q[int'(blk_q) * R +: R];

    // Terms past the end of the block are masked so their shift never indexes outside pos_q.
    always_comb begin
        rot_shift = '0;
        term_en   = '0;
        for (int t = 0; t < P; t++) begin
            term_en[t] = (k_q + KW'(t)) < WK;
            if (term_en[t]) begin
                rot_shift[t] = pos_q[(int'(blk_q) * W + int'(k_q) + t) * POS_W +: POS_W];
            end
        end
    end

    for (genvar g = 0; g < P; g++) begin : g_rot
        qc_rot_unit #(
            .R     (R),
            .POS_W (POS_W)
        ) u_rot (
            .x            (rot_x),
            .shift        (rot_shift[g]),
            .dir          (mode_q),
            .y            (rot_y[g]),
            .out_of_range (rot_oor[g])
        );
    end

    always_comb begin
        run_sum = '0;
        run_oor = 1'b0;
        for (int t = 0; t < P; t++) begin
            if (term_en[t]) begin
                run_sum ^= rot_y[t];
                run_oor |= rot_oor[t];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        b_d       = b_q;
        pos_d     = pos_q;
        mode_d    = mode_q;
        acc_d     = acc_q;
        blk_d     = blk_q;
        k_d       = k_q;
        err_acc_d = err_acc_q;
        s_d       = s_q;
        err_d     = err_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid && !abort) begin
                    b_d       = b_flat;
                    pos_d     = pos_flat;
                    mode_d    = mode;
                    acc_d     = '0;
                    blk_d     = '0;
                    k_d       = '0;
                    err_acc_d = 1'b0;
                    state_d   = StRun;
                end
            end
            StRun: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    acc_d     = acc_q ^ run_sum;
                    err_acc_d = err_acc_q | run_oor;
                    if ((k_q + PK) >= WK) begin
                        k_d = '0;
                        if (blk_q == LastBlk) begin
                            blk_d   = '0;
                            s_d     = acc_d;
                            err_d   = err_acc_d;
                            state_d = StHold;
                        end else begin
                            blk_d = blk_q + 1'b1;
                        end
                    end else begin
                        k_d = k_q + PK;
                    end
                end
            end
            StHold: begin
                if (abort || out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            b_q       <= '0;
            pos_q     <= '0;
            mode_q    <= 1'b0;
            acc_q     <= '0;
            blk_q     <= '0;
            k_q       <= '0;
            err_acc_q <= 1'b0;
            s_q       <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            b_q       <= b_d;
            pos_q     <= pos_d;
            mode_q    <= mode_d;
            acc_q     <= acc_d;
            blk_q     <= blk_d;
            k_q       <= k_d;
            err_acc_q <= err_acc_d;
            s_q       <= s_d;
            err_q     <= err_d;
        end
    end

    assign in_ready  = (state_q == StIdle) && !rst;
    assign out_valid = (state_q == StHold);
    assign s         = s_q;
    assign err       = err_q;

endmodule

// File: tb/tb_qc_sparse_mac.sv
// Randomised self-checking bench for qc_sparse_mac against a bit-level GF(2) reference model,
// plus P=1 and P=W instances that must agree on identical jobs.
module tb_qc_sparse_mac;

    localparam int R     = 127;
    localparam int W     = 5;
    localparam int POS_W = 8;
    localparam int NB    = 2;
    localparam int P     = 4;
    localparam int LAT   = NB * ((W + P - 1) / P);

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic                  mode;
    logic [NB*R-1:0]       b_flat;
    logic [NB*W*POS_W-1:0] pos_flat;
    logic                  abort;
    logic                  out_ready;
    logic                  in_ready, out_valid, err;
    logic [R-1:0]          s;
    logic                  in_ready_a, out_valid_a, err_a;
    logic [R-1:0]          s_a;
    logic                  in_ready_c, out_valid_c, err_c;
    logic [R-1:0]          s_c;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    qc_sparse_mac #(.R(R), .W(W), .POS_W(POS_W), .NB(NB), .P(P)) u_dut (
        .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (in_ready), .mode (mode),
        .b_flat (b_flat), .pos_flat (pos_flat), .abort (abort), .out_valid (out_valid),
        .out_ready (out_ready), .s (s), .err (err)
    );

    qc_sparse_mac #(.R(R), .W(W), .POS_W(POS_W), .NB(NB), .P(1)) u_dut_p1 (
        .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (in_ready_a), .mode (mode),
        .b_flat (b_flat), .pos_flat (pos_flat), .abort (abort), .out_valid (out_valid_a),
        .out_ready (out_ready), .s (s_a), .err (err_a)
    );

    qc_sparse_mac #(.R(R), .W(W), .POS_W(POS_W), .NB(NB), .P(W)) u_dut_pw (
        .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (in_ready_c), .mode (mode),
        .b_flat (b_flat), .pos_flat (pos_flat), .abort (abort), .out_valid (out_valid_c),
        .out_ready (out_ready), .s (s_c), .err (err_c)
    );

    // Reference: s = XOR over blocks/terms of b_j rotated by pos; {err, s}.
    function automatic logic [R:0] model(input logic [NB*R-1:0] b,
                                         input logic [NB*W*POS_W-1:0] pos, input logic md);
        logic [R-1:0] acc;
        logic         e;
        int           p, dst;
        acc = '0;
        e   = 1'b0;
        for (int j = 0; j < NB; j++) begin
            for (int i = 0; i < W; i++) begin
                p = int'(pos[(j*W+i)*POS_W +: POS_W]);
                if (p >= R) begin
                    e = 1'b1;
                end else begin
                    for (int n = 0; n < R; n++) begin
                        if (b[j*R+n]) begin
                            dst = md ? (n - p + R) % R : (n + p) % R;
                            acc[dst] = ~acc[dst];
                        end
                    end
                end
            end
        end
        return {e, acc};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pos(input int j, input int i, input int v);
        pos_flat[(j*W+i)*POS_W +: POS_W] = v[POS_W-1:0];
    endtask

    task automatic set_blk0(input int a, input int b, input int c, input int d, input int e);
        set_pos(0, 0, a); set_pos(0, 1, b); set_pos(0, 2, c); set_pos(0, 3, d); set_pos(0, 4, e);
    endtask

    task automatic clear_job();
        b_flat   = '0;
        pos_flat = '0;
        mode     = 1'b0;
        for (int i = 0; i < W; i++) set_pos(1, i, int'($urandom_range(0, R - 1)));
    endtask

    task automatic rand_job();
        int v;
        for (int n = 0; n < NB*R; n++) b_flat[n] = ($urandom() % 2) == 1;
        for (int j = 0; j < NB; j++) begin
            for (int i = 0; i < W; i++) begin
                v = (($urandom() % 8) == 0) ? int'($urandom_range(R, 255))
                                            : int'($urandom_range(0, R - 1));
                set_pos(j, i, v);
            end
        end
        mode = ($urandom() % 2) == 1;
    endtask

    // Accept one job and wait (bounded) for out_valid; lat counts cycles after the accept edge.
    task automatic launch(output int lat);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; mode = 1'b0; abort = 1'b0; out_ready = 1'b1;
        b_flat = '0; pos_flat = '0;
        #3;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || s !== '0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b ov=%b s=%h err=%b want 0 0 0 0",
                     in_ready, out_valid, s, err);
        end
        step(); step();
        rst = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got rdy=%b ov=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        logic [R-1:0] exp_s;
        int           lat;
        // Identity-like product with positions 0..4.
        clear_job(); b_flat[0] = 1'b1; set_blk0(0, 1, 2, 3, 4);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL dirA_ready: got %b want 1", in_ready);
        end
        launch(lat);
        exp_s = '0; exp_s[4:0] = 5'h1f;
        checks++;
        if (lat != LAT) begin errors++; $display("FAIL dirA_latency: got %0d want %0d", lat, LAT); end
        checks++;
        if (s !== exp_s || err !== 1'b0) begin
            errors++; $display("FAIL dirA_result: got s=%h err=%b want s=%h err=0", s, err, exp_s);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL dirA_consume: got ov=%b rdy=%b want 0 1", out_valid, in_ready);
        end
        // Transpose wraps below bit 0.
        clear_job(); b_flat[0] = 1'b1; set_blk0(1, 2, 3, 4, 5); mode = 1'b1;
        launch(lat);
        exp_s = '0; exp_s[126:122] = 5'h1f;
        checks++;
        if (s !== exp_s || err !== 1'b0) begin
            errors++; $display("FAIL dirB_mode1: got s=%h err=%b want s=%h", s, err, exp_s);
        end
        step();
        mode = 1'b0;
        launch(lat);
        exp_s = '0; exp_s[5:1] = 5'h1f;
        checks++;
        if (s !== exp_s) begin
            errors++; $display("FAIL dirB_mode0: got s=%h want s=%h", s, exp_s);
        end
        step();
        // Duplicate positions cancel pairwise.
        clear_job(); b_flat[0] = 1'b1; set_blk0(7, 7, 0, 0, 0);
        launch(lat);
        exp_s = '0; exp_s[0] = 1'b1;
        checks++;
        if (s !== exp_s || err !== 1'b0) begin
            errors++; $display("FAIL dirC_dup: got s=%h err=%b want s=%h err=0", s, err, exp_s);
        end
        step();
        // Out-of-range term dropped and flagged.
        clear_job(); b_flat[0] = 1'b1; set_blk0(200, 1, 2, 3, 4);
        launch(lat);
        exp_s = '0; exp_s[4:1] = 4'hf;
        checks++;
        if (s !== exp_s || err !== 1'b1) begin
            errors++; $display("FAIL dirD_range: got s=%h err=%b want s=%h err=1", s, err, exp_s);
        end
        step();
        clear_job(); b_flat[0] = 1'b1; set_blk0(0, 1, 2, 3, 4);
        launch(lat);
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL dirD_clean: got err=%b want 0", err);
        end
        step();
    endtask

    task automatic test_random();
        logic [R:0] exp;
        int         lat;
        for (int it = 0; it < 24; it++) begin
            rand_job();
            exp = model(b_flat, pos_flat, mode);
            launch(lat);
            checks++;
            if (lat != LAT || {err, s} !== exp) begin
                errors++;
                $display("FAIL rand_%0d: got lat=%0d err=%b s=%h want lat=%0d err=%b s=%h",
                         it, lat, err, s, LAT, exp[R], exp[R-1:0]);
            end
            step();
        end
    endtask

    task automatic test_hold_stall();
        logic [R:0] exp;
        int         lat, bad;
        rand_job();
        exp = model(b_flat, pos_flat, mode);
        out_ready = 1'b0;
        launch(lat);
        checks++;
        if ({err, s} !== exp) begin
            errors++; $display("FAIL stall_result: got err=%b s=%h want err=%b s=%h",
                               err, s, exp[R], exp[R-1:0]);
        end
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin rand_job(); in_valid = 1'b1; end
            step();
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {err, s} !== exp) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL stall_stable: got %0d unstable cycles want 0", bad);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || {err, s} !== exp) begin
            errors++; $display("FAIL stall_release: got ov=%b rdy=%b s=%h want 0 1 s=%h",
                               out_valid, in_ready, s, exp[R-1:0]);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        clear_job(); b_flat[0] = 1'b1; set_blk0(0, 1, 2, 3, 4);
        launch(lat);
        step();
        rand_job();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || s !== '0 || err !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL rst_mid_run: got ov=%b s=%h err=%b rdy=%b want 0 0 0 0",
                               out_valid, s, err, in_ready);
        end
        step();
        rst = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL rst_mid_release: got rdy=%b ov=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_abort();
        logic [R-1:0] prev;
        logic [R:0]   exp;
        int           lat, bad;
        clear_job(); b_flat[0] = 1'b1; set_blk0(0, 1, 2, 3, 4);
        launch(lat);
        prev = s;
        step();
        clear_job(); b_flat[0] = 1'b1; set_blk0(1, 2, 3, 4, 5); mode = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL abort_run: got rdy=%b ov=%b want 1 0", in_ready, out_valid);
        end
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (out_valid !== 1'b0 || s !== prev) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL abort_no_result: got %0d bad cycles want 0", bad);
        end
        abort = 1'b1; in_valid = 1'b1;
        step();
        abort = 1'b0; in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL abort_idle_priority: got rdy=%b want 1", in_ready);
        end
        rand_job();
        exp = model(b_flat, pos_flat, mode);
        out_ready = 1'b0;
        launch(lat);
        abort = 1'b1;
        step();
        abort = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || {err, s} !== exp) begin
            errors++; $display("FAIL abort_hold: got ov=%b rdy=%b s=%h want 0 1 s=%h",
                               out_valid, in_ready, s, exp[R-1:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [R:0] q[$];
        logic [R:0] exp;
        logic       acc;
        int         last, nout;
        last = -1; nout = 0;
        out_ready = 1'b1;
        rand_job();
        in_valid = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (c >= 48) in_valid = 1'b0;
            if (out_valid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL b2b_unexpected: got result at cycle %0d want none", c);
                end else begin
                    exp = q.pop_front();
                    if ({err, s} !== exp) begin
                        errors++; $display("FAIL b2b_result: got err=%b s=%h want err=%b s=%h",
                                           err, s, exp[R], exp[R-1:0]);
                    end
                end
                if (last >= 0) begin
                    checks++;
                    if (c - last != LAT + 2) begin
                        errors++; $display("FAIL b2b_spacing: got %0d want %0d", c - last, LAT + 2);
                    end
                end
                last = c;
                nout++;
            end
            acc = in_ready && in_valid;
            if (acc) q.push_back(model(b_flat, pos_flat, mode));
            step();
            if (acc) rand_job();
        end
        checks++;
        if (q.size() != 0 || nout < 7) begin
            errors++; $display("FAIL b2b_count: got %0d results %0d pending want >=7 and 0",
                               nout, q.size());
        end
    endtask

    task automatic test_p_variants();
        logic [R:0] exp;
        int         waited;
        for (int it = 0; it < 4; it++) begin
            abort = 1'b1;
            step();
            abort = 1'b0;
            if (it == 0) begin
                clear_job(); b_flat[0] = 1'b1; set_blk0(7, 7, 0, 0, 0);
            end else begin
                rand_job();
            end
            exp = model(b_flat, pos_flat, mode);
            out_ready = 1'b0;
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            waited = 0;
            while (!(out_valid && out_valid_a && out_valid_c) && waited < 40) begin
                step();
                waited++;
            end
            checks++;
            if (waited >= 40) begin
                errors++; $display("FAIL pvar_timeout_%0d: got ov=%b%b%b want 111",
                                   it, out_valid, out_valid_a, out_valid_c);
            end
            checks++;
            if ({err_a, s_a} !== exp || {err_c, s_c} !== exp || {err, s} !== exp) begin
                errors++; $display("FAIL pvar_result_%0d: got p1=%h pw=%h p=%h want %h",
                                   it, {err_a, s_a}, {err_c, s_c}, {err, s}, exp);
            end
            out_ready = 1'b1;
            step();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_hold_stall();
        test_reset_mid_run();
        test_abort();
        test_back_to_back();
        test_p_variants();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by 500us want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
